// File: rtl/status_tx_pkg.sv
// Shared types and constants for the status frame sent back to the MCU.
// The snapshot packing matches the receive-side command path byte order.
package status_tx_pkg;

  localparam int STATUS_WIDTH = 8;
  localparam int STATUS_WORD  = 32;
  localparam int STATUS_N_OSC = 16;

  localparam logic [7:0] STATUS_HEADER = 8'hA5;

  typedef struct packed {
    logic [STATUS_WORD-1:0]  volume;
    logic [STATUS_WORD-1:0]  reverb;
    logic [STATUS_N_OSC-1:0] osc_active;
  } status_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CSUM
  } tx_state_t;

  // Header word, every payload word, then the checksum word.
  function automatic int frame_len(input int width, input int word, input int n_osc);
    return 1 + (2 * word) / width + n_osc / width + 1;
  endfunction

endpackage

// File: rtl/status_tx.sv
// Serializes a status snapshot (header, volume, reverb, oscillator mask, XOR
// checksum) into WIDTH-bit words for the SPI slave using a valid/ready handshake.
module status_tx
  import status_tx_pkg::*;
#(
  parameter int WIDTH = STATUS_WIDTH,
  parameter int WORD  = STATUS_WORD,
  parameter int N_OSC = STATUS_N_OSC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WORD-1:0]  volume,
  input  logic [WORD-1:0]  reverb,
  input  logic [N_OSC-1:0] osc_active,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done
);

  localparam int N_WORDS   = (2 * WORD + N_OSC) / WIDTH;
  localparam int FRAME_LEN = frame_len(WIDTH, WORD, N_OSC);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_PAYLOAD = IDX_W'(FRAME_LEN - 2);

  tx_state_t               state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]        csum_q, csum_d;
  status_t                 snap_q, snap_d;
  logic                    done_q, done_d;

  logic [N_WORDS-1:0][WIDTH-1:0] snapWords;
  logic [IDX_W-1:0]              wordSel;
  logic [WIDTH-1:0]              txWord;

  // Index 1 is the most significant snapshot word, which lives at the top of the packed array.
  assign snapWords = snap_q;
  assign wordSel   = IDX_W'(N_WORDS) - idx_q;

  always_comb begin
    txWord = '0;
    case (state_q)
      SEND:    txWord = (idx_q == '0) ? STATUS_HEADER : snapWords[wordSel];
      CSUM:    txWord = csum_q;
      default: txWord = '0;
    endcase
  end

  assign tx_valid = (state_q == SEND) || (state_q == CSUM);
  assign tx_data  = txWord;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // Abort wins over everything; start is ignored during the done pulse so a new frame needs a clean IDLE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    snap_d  = snap_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            snap_d  = '{volume: volume, reverb: reverb, osc_active: osc_active};
            idx_d   = '0;
            csum_d  = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            csum_d = csum_q ^ txWord;
            idx_d  = idx_q + 1'b1;
            if (idx_q == LAST_PAYLOAD) begin
              state_d = CSUM;
            end
          end
        end
        CSUM: begin
          if (tx_ready) begin
            done_d  = 1'b1;
            idx_d   = '0;
            csum_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_status_tx.sv
// Directed bench for status_tx: a vector table for the plain frame plus
// hand-written sequences for stalls, snapshot isolation, abort and reset.
module tb_status_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] volume;
  logic [31:0] reverb;
  logic [15:0] oscActive;
  logic        txReady;
  logic        txValid;
  logic [7:0]  txData;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Hand-computed frame for volume=01020304, reverb=0000FFFF, osc=8001.
  logic [7:0] expWords [12];

  typedef struct {
    logic       start;
    logic       txReady;
    logic       expValid;
    logic [7:0] expData;
    logic       expBusy;
    logic       expDone;
  } vec_t;

  vec_t vecs [15];

  status_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .volume    (volume),
    .reverb    (reverb),
    .osc_active(oscActive),
    .tx_ready  (txReady),
    .tx_valid  (txValid),
    .tx_data   (txData),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start   = s;
    abort   = a;
    txReady = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input string tag, input int stallEvery, input bit midVolume,
                          input bit midStart, input bit doneStart);
    int   k;
    bit   finished;
    logic r;
    logic s;
    k        = 0;
    finished = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, " idle busy"}, busy, 0);
    nextCycle();
    for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
      r = (stallEvery == 0) || ((cyc % stallEvery) != (stallEvery - 1));
      s = (midStart && cyc == 3) || (doneStart && k == 12);
      applyStimulus(s, 1'b0, r);
      if (midVolume && cyc == 1) volume = 32'hFFFF_FFFF;
      @(negedge clk);
      if (k < 12) begin
        checkOutput($sformatf("%s valid w%0d", tag, k), txValid, 1);
        checkOutput($sformatf("%s data w%0d", tag, k), txData, expWords[k]);
        checkOutput($sformatf("%s early done w%0d", tag, k), done, 0);
        if (r) k++;
      end else begin
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " valid after csum"}, txValid, 0);
        checkOutput({tag, " busy after csum"}, busy, 0);
        finished = 1;
      end
      nextCycle();
    end
    if (!finished) checkOutput({tag, " timeout"}, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, " done single"}, done, 0);
    checkOutput({tag, " busy idle"}, busy, 0);
    checkOutput({tag, " valid idle"}, txValid, 0);
    nextCycle();
    volume = 32'h0102_0304;
  endtask

  initial begin
    expWords = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00,
                 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h01, 8'h20};

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    rst       = 1'b1;
    volume    = 32'h0102_0304;
    reverb    = 32'h0000_FFFF;
    oscActive = 16'h8001;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset valid", txValid, 0);
    checkOutput("reset data", txData, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nextCycle();

    // Plain frame from the vector table.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].start, 1'b0, vecs[i].txReady);
      @(negedge clk);
      checkOutput($sformatf("basic[%0d] valid", i), txValid, vecs[i].expValid);
      checkOutput($sformatf("basic[%0d] data", i), txData, vecs[i].expData);
      checkOutput($sformatf("basic[%0d] busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("basic[%0d] done", i), done, vecs[i].expDone);
      nextCycle();
    end

    runFrame("backpressure", 3, 1'b0, 1'b0, 1'b0);
    runFrame("snapshot", 0, 1'b1, 1'b0, 1'b0);
    runFrame("startBusy", 0, 1'b0, 1'b1, 1'b0);
    runFrame("startOnDone", 2, 1'b0, 1'b0, 1'b1);

    // Abort after five accepted words, asserted together with tx_ready.
    applyStimulus(1'b1, 1'b0, 1'b1);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("abort pre w%0d", i), txData, expWords[i]);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("abort pending valid", txValid, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort valid", txValid, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("abort no late done", done, 0);
    nextCycle();
    runFrame("afterAbort", 0, 1'b0, 1'b0, 1'b0);

    // Reset asserted between clock edges in the middle of a frame.
    applyStimulus(1'b1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async valid", txValid, 0);
    checkOutput("async busy", busy, 0);
    checkOutput("async done", done, 0);
    checkOutput("async data", txData, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nextCycle();
    runFrame("afterReset", 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_tx.md
Name: status_tx

Overview:
- Transmit-side counterpart of the MCU command path. Serializes a status frame back to the MCU, WIDTH bits at a time, for the SPI slave to shift out on MISO.
- Frame layout, MSB-first and big-endian to match the receive-side byte order: header, master volume, reverb, oscillator-active mask, XOR checksum.
- Sits between the control unit/oscillator bank (data sources) and the SPI slave (byte sink).

Parameters:
- WIDTH, 8, bits per transmitted word. Must be 8 (header constant is 8 bits).
- WORD, 32, width of volume/reverb values. Must be a multiple of WIDTH.
- N_OSC, `N_OSCILLATORS (16), number of oscillator-active bits. Must be a multiple of WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a frame. Sampled only in IDLE.
- abort  in  1  chip-select deassert. Drops the current frame.
- volume  in  WORD  master volume to report.
- reverb  in  WORD  reverb value to report.
- osc_active  in  N_OSC  per-oscillator active flags. Bit N_OSC-1 is sent first.
- tx_ready  in  1  SPI slave can accept a word this cycle.
- tx_valid  out  1  tx_data holds a valid word.
- tx_data  out  WIDTH  word to transmit.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the checksum word is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE; tx_valid=0, tx_data=0, busy=0, done=0; index=0, checksum=0, snapshot=0.
- Frame length: FRAME_LEN = 1 + 2*WORD/WIDTH + N_OSC/WIDTH + 1. This is 12 with the defaults.
- States:
  - IDLE. On start=1 (and abort=0): latch {volume, reverb, osc_active} into the snapshot register, index=0, checksum=0, go to SEND. busy=1 and tx_valid=1 from the next cycle; latency start→first valid is 1 cycle.
  - SEND. tx_data = STATUS_HEADER (0xA5) at index 0, else snapshot word index-1, MSB-first. tx_valid=1. On tx_valid&&tx_ready: checksum ^= tx_data, index++. When the last payload word (index FRAME_LEN-2) is accepted, go to CSUM.
  - CSUM. tx_data = checksum (XOR of header and all payload words), tx_valid=1. On acceptance: done=1 for exactly that next cycle, busy=0, tx_valid=0, back to IDLE.
- Handshake: tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0. Back-to-back acceptance gives one word per cycle. tx_ready is ignored while tx_valid=0.
- Inputs changing mid-frame have no effect; only the start-cycle snapshot is sent.
- start while busy: ignored, no restart.
- start on the same cycle as done: ignored. A new frame needs start in IDLE.
- abort=1 in any state: next cycle IDLE, tx_valid=0, busy=0, done not pulsed, checksum cleared. abort has priority over start and over tx_ready acceptance in the same cycle.
- Reset mid-frame: immediate return to reset values, no done.
- Index counter width: $clog2(FRAME_LEN). No wrap-around; the frame ends explicitly.

Decomposition:
- protocol_pkg gets:
  - STATUS_HEADER (8'hA5).
  - status_t packed struct {logic [WORD-1:0] volume; logic [WORD-1:0] reverb; logic [N_OSC-1:0] osc_active}.
  - tx_state_t enum {IDLE, SEND, CSUM}.
  - A function returning FRAME_LEN.
- The snapshot is a packed status_t viewed as an array of WIDTH-bit words, using the same packing as the receive side.
- No sub-module needed; the XOR checksum is a single register.

Test Plan:
- Basic frame: volume=0x01020304, reverb=0x0000FFFF, osc_active=0x8001, start pulse, tx_ready held 1. Required:
  - words A5 01 02 03 04 00 00 FF FF 80 01 20 on 12 consecutive cycles, first one cycle after start;
  - done pulses once after 0x20;
  - busy low afterwards.
- Backpressure: same inputs, tx_ready toggled with a 1-in-3 pattern. Required: identical word sequence, tx_data stable during each stall, done only after 0x20 is accepted.
- Snapshot isolation: start, then change volume to 0xFFFFFFFF on cycle 2. Required: frame still carries 01 02 03 04 and checksum 0x20.
- Abort: abort asserted after the 5th word is accepted. Required: tx_valid=0 and busy=0 next cycle, no done. A following start sends a full fresh frame beginning with A5.
- Start while busy: second start pulse at word 3. Required: no restart, exactly 12 words, one done.
- Async reset: rst asserted mid-frame between clock edges. Required: tx_valid, busy and done go to 0 immediately without a clock edge; after release the block is in IDLE and accepts start.
